// File: rtl/conv_sched_pkg.sv
// Shared definitions for the conv_unit_scheduler slice.
//   state_t    : sequencer states IDLE..DONE (fixed encodings)
//   MAC_EN     : bit index of the MAC enable inside each column's PE control slice
//   CW_DEFAULT : default config field width
//   drain_len  : cycles the skew line needs to empty after the last read
package conv_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam int unsigned MAC_EN     = 0;
   localparam int unsigned CW_DEFAULT = 8;

   // One cycle of buffer read latency plus one skew stage per column.
   function automatic int unsigned drain_len(input int unsigned d);
      return d + 1;
   endfunction

endpackage

// File: rtl/conv_ctrl_skew.sv
// Column-skewed PE control line: column j sees the enable delayed by 1+j cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : single MAC enable (the buffer read strobe)
//   pe_ctrl    : D*PE_CTRL control vector, column j in [PE_CTRL*(j+1)-1 -: PE_CTRL]
module conv_ctrl_skew
   import conv_sched_pkg::*;
#(
   parameter int unsigned D       = 4,
   parameter int unsigned PE_CTRL = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   output logic [D*PE_CTRL-1:0] pe_ctrl
);

   // Shared shift line; tap j is 1+j stages behind en.
   logic [D-1:0] line;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) line <= '0;
      else        line <= (line << 1) | D'(en);
   end

   // Only the MAC bit of each column is driven; any extra control bits stay 0.
   always_comb begin
      pe_ctrl = '0;
      for (int unsigned j = 0; j < D; j++) begin
         pe_ctrl[PE_CTRL*j + MAC_EN] = line[j];
      end
   end

endmodule

// File: rtl/conv_unit_scheduler.sv
// Tile sequencer for the D x D PE mesh: walks output tiles (px inner, oc outer),
// streams kernel/neuron buffer reads, skews the PE MAC enable across columns and
// writes each finished tile's partial sums to the output buffer.
//   clk, rst_n           : clock, asynchronous active-low reset (aborts a job)
//   start                : one-cycle request, honoured only in IDLE
//   cfg_k/c/oc_tiles/px_tiles : job configuration, latched on start
//   busy, done           : job status; done pulses once at job end
//   kbuf_*/nbuf_*        : buffer read strobes and addresses
//   pe_ctrl, psum_zero   : mesh control
//   obuf_wr_en/addr      : output buffer write
// Optional: `CONV_SCHED_PERF_EN adds perf_cycles (busy cycles of the last job).
module conv_unit_scheduler
   import conv_sched_pkg::*;
#(
   parameter int unsigned depth   = 2,
   parameter int unsigned A       = 7,
   parameter int unsigned PE_CTRL = 1,
   parameter int unsigned CW      = CW_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [CW-1:0]                 cfg_k,
   input  logic [CW-1:0]                 cfg_c,
   input  logic [CW-1:0]                 cfg_oc_tiles,
   input  logic [CW-1:0]                 cfg_px_tiles,
   output logic                          busy,
   output logic                          done,
   output logic                          kbuf_rd_en,
   output logic [A-1:0]                  kbuf_addr,
   output logic                          nbuf_rd_en,
   output logic [A-1:0]                  nbuf_addr,
   output logic [(1<<depth)*PE_CTRL-1:0] pe_ctrl,
   output logic                          psum_zero,
   output logic                          obuf_wr_en,
   output logic [A-1:0]                  obuf_addr
`ifdef CONV_SCHED_PERF_EN
   ,
   output logic [31:0]                   perf_cycles
`endif
);

   localparam int unsigned D    = 1 << depth;
   localparam int unsigned PW   = 3 * CW;
   localparam int unsigned DL   = drain_len(D);
   localparam int unsigned CNTW = $clog2(DL + 1);

   state_t          state;
   logic [CW-1:0]   k_q, c_q, oct_q, pxt_q, oc_q, px_q;
   logic [A-1:0]    l_q, r_q, kbase_q, nbase_q, oaddr_q;
   logic [CNTW-1:0] dcnt_q;
   logic            rd_en_q;

   logic [PW-1:0]   prod_c;
   logic            prod_unused_c;
   logic [A-1:0]    l_c, kbase_nx_c, nbase_nx_c;
   logic            last_px_c, last_oc_c;

   // Reduction length at full width, then wrapped to the address width.
   assign prod_c        = PW'(k_q) * PW'(k_q) * PW'(c_q);
   assign l_c           = A'(prod_c);
   assign prod_unused_c = ^prod_c[PW-1:A];

   // Next-tile bases: px is the inner loop, so oc (kernel base) only moves on px wrap.
   assign last_px_c  = (px_q == pxt_q - CW'(1));
   assign last_oc_c  = (oc_q == oct_q - CW'(1));
   assign kbase_nx_c = last_px_c ? kbase_q + l_q : kbase_q;
   assign nbase_nx_c = last_px_c ? '0 : nbase_q + l_q;

   assign kbuf_rd_en = rd_en_q;
   assign nbuf_rd_en = rd_en_q;
   assign psum_zero  = busy;

   // Sequencer: outputs are registered alongside the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         k_q        <= '0;
         c_q        <= '0;
         oct_q      <= '0;
         pxt_q      <= '0;
         oc_q       <= '0;
         px_q       <= '0;
         l_q        <= '0;
         r_q        <= '0;
         kbase_q    <= '0;
         nbase_q    <= '0;
         oaddr_q    <= '0;
         dcnt_q     <= '0;
         rd_en_q    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         kbuf_addr  <= '0;
         nbuf_addr  <= '0;
         obuf_wr_en <= 1'b0;
         obuf_addr  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  k_q     <= cfg_k;
                  c_q     <= cfg_c;
                  oct_q   <= cfg_oc_tiles;
                  pxt_q   <= cfg_px_tiles;
                  oc_q    <= '0;
                  px_q    <= '0;
                  kbase_q <= '0;
                  nbase_q <= '0;
                  oaddr_q <= '0;
                  busy    <= 1'b1;
                  state   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               l_q       <= l_c;
               r_q       <= '0;
               kbuf_addr <= '0;
               nbuf_addr <= '0;
               if (l_c == '0 || oct_q == '0 || pxt_q == '0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  rd_en_q <= 1'b1;
                  state   <= ST_FEED;
               end
            end
            ST_FEED: begin
               if (r_q == l_q - A'(1)) begin
                  rd_en_q <= 1'b0;
                  dcnt_q  <= '0;
                  state   <= ST_DRAIN;
               end else begin
                  r_q       <= r_q + A'(1);
                  kbuf_addr <= kbase_q + r_q + A'(1);
                  nbuf_addr <= nbase_q + r_q + A'(1);
               end
            end
            ST_DRAIN: begin
               if (dcnt_q == CNTW'(DL - 1)) begin
                  obuf_wr_en <= 1'b1;
                  obuf_addr  <= oaddr_q;
                  state      <= ST_WRITE;
               end else begin
                  dcnt_q <= dcnt_q + CNTW'(1);
               end
            end
            ST_WRITE: begin
               obuf_wr_en <= 1'b0;
               // Output tiles are written in issue order, so the address is a running count.
               oaddr_q    <= oaddr_q + A'(1);
               px_q       <= last_px_c ? '0 : px_q + CW'(1);
               if (last_px_c) oc_q <= oc_q + CW'(1);
               kbase_q    <= kbase_nx_c;
               nbase_q    <= nbase_nx_c;
               if (last_px_c && last_oc_c) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  r_q       <= '0;
                  rd_en_q   <= 1'b1;
                  kbuf_addr <= kbase_nx_c;
                  nbuf_addr <= nbase_nx_c;
                  state     <= ST_FEED;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   conv_ctrl_skew #(
      .D       (D),
      .PE_CTRL (PE_CTRL)
   ) u_skew (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (rd_en_q),
      .pe_ctrl (pe_ctrl)
   );

`ifdef CONV_SCHED_PERF_EN
   // Busy-cycle counter of the most recent job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        perf_cycles <= '0;
      else if (state == ST_IDLE && start) perf_cycles <= '0;
      else if (busy)                     perf_cycles <= perf_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_conv_unit_scheduler.sv
// Bench for conv_unit_scheduler: directed and random jobs compared cycle by cycle
// against a tile-level timing/address model built from the job configuration.
module tb_conv_unit_scheduler;

   localparam int unsigned DEPTH   = 2;
   localparam int unsigned D       = 4;
   localparam int unsigned A       = 7;
   localparam int unsigned PE_CTRL = 1;
   localparam int unsigned CW      = 8;
   localparam int unsigned AMOD    = 1 << A;

   logic                  clk, rst_n, start;
   logic [CW-1:0]         cfg_k, cfg_c, cfg_oc_tiles, cfg_px_tiles;
   logic                  busy, done, kbuf_rd_en, nbuf_rd_en, psum_zero, obuf_wr_en;
   logic [A-1:0]          kbuf_addr, nbuf_addr, obuf_addr;
   logic [D*PE_CTRL-1:0]  pe_ctrl;
`ifdef CONV_SCHED_PERF_EN
   logic [31:0]           perf_cycles;
`endif

   conv_unit_scheduler #(
      .depth(DEPTH), .A(A), .PE_CTRL(PE_CTRL), .CW(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_k(cfg_k), .cfg_c(cfg_c), .cfg_oc_tiles(cfg_oc_tiles), .cfg_px_tiles(cfg_px_tiles),
      .busy(busy), .done(done),
      .kbuf_rd_en(kbuf_rd_en), .kbuf_addr(kbuf_addr),
      .nbuf_rd_en(nbuf_rd_en), .nbuf_addr(nbuf_addr),
      .pe_ctrl(pe_ctrl), .psum_zero(psum_zero),
      .obuf_wr_en(obuf_wr_en), .obuf_addr(obuf_addr)
`ifdef CONV_SCHED_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected behaviour per cycle, indexed by cycles after the start-driving negedge.
   bit erd[], ewr[], ebusy[], edone[];
   int eka[], ena[], eoa[];
   int done_rel, nlen;

   task automatic build_model(input int k, input int c, input int oct, input int pxt);
      int l, nt, tt, f;
      bit empty;
      l     = (k * k * c) % AMOD;
      empty = (l == 0) || (oct == 0) || (pxt == 0);
      nt    = oct * pxt;
      tt    = l + D + 2;                       // FEED + DRAIN(D+1) + WRITE
      done_rel = empty ? 2 : 2 + nt * tt;
      nlen  = done_rel + 3;
      erd = new[nlen]; ewr = new[nlen]; ebusy = new[nlen]; edone = new[nlen];
      eka = new[nlen]; ena = new[nlen]; eoa = new[nlen];
      for (int i = 0; i < nlen; i++) begin
         erd[i] = 0; ewr[i] = 0; eka[i] = 0; ena[i] = 0; eoa[i] = 0;
         ebusy[i] = (i >= 1) && (i < done_rel);
         edone[i] = (i == done_rel);
      end
      if (!empty) begin
         for (int t = 0; t < nt; t++) begin
            f = 2 + t * tt;
            for (int r = 0; r < l; r++) begin
               erd[f + r] = 1;
               eka[f + r] = ((t / pxt) * l + r) % AMOD;
               ena[f + r] = ((t % pxt) * l + r) % AMOD;
            end
            ewr[f + l + D + 1] = 1;
            eoa[f + l + D + 1] = t % AMOD;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_krd"}, kbuf_rd_en, 0);
      check({tag, "_nrd"}, nbuf_rd_en, 0);
      check({tag, "_kaddr"}, kbuf_addr, 0);
      check({tag, "_naddr"}, nbuf_addr, 0);
      check({tag, "_pe"}, pe_ctrl, 0);
      check({tag, "_psz"}, psum_zero, 0);
      check({tag, "_wr"}, obuf_wr_en, 0);
      check({tag, "_oaddr"}, obuf_addr, 0);
`ifdef CONV_SCHED_PERF_EN
      check({tag, "_perf"}, perf_cycles, 0);
`endif
   endtask

   // Runs one job; hold keeps start high until the DONE cycle, toggle scrambles cfg
   // mid-job, abort_rel > 0 pulls reset at that cycle instead of finishing.
   task automatic run_job(input int k, input int c, input int oct, input int pxt,
                          input bit hold, input bit toggle, input int abort_rel);
      logic [D*PE_CTRL-1:0] pv;
      int busy_cnt;
      @(negedge clk);
      cfg_k = CW'(k); cfg_c = CW'(c); cfg_oc_tiles = CW'(oct); cfg_px_tiles = CW'(pxt);
      start = 1'b1;
      build_model(k, c, oct, pxt);
      busy_cnt = 0;
      for (int rel = 1; rel < nlen; rel++) begin
         @(negedge clk);
         pv = '0;
         for (int j = 0; j < D; j++)
            if (rel >= 1 + j && erd[rel - 1 - j]) pv[j*PE_CTRL] = 1'b1;
         if (busy) busy_cnt++;
         check("busy", busy, 32'(ebusy[rel]));
         check("done", done, 32'(edone[rel]));
         check("psum_zero", psum_zero, 32'(ebusy[rel]));
         check("kbuf_rd_en", kbuf_rd_en, 32'(erd[rel]));
         check("nbuf_rd_en", nbuf_rd_en, 32'(erd[rel]));
         check("pe_ctrl", pe_ctrl, 32'(pv));
         check("obuf_wr_en", obuf_wr_en, 32'(ewr[rel]));
         if (erd[rel]) begin
            check("kbuf_addr", kbuf_addr, eka[rel]);
            check("nbuf_addr", nbuf_addr, ena[rel]);
         end
         if (ewr[rel]) check("obuf_addr", obuf_addr, eoa[rel]);
         if (abort_rel > 0 && rel == abort_rel) begin
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            check_all_zero("abort");
            @(negedge clk);
            check_all_zero("abort_hold");
            rst_n = 1'b1;
            return;
         end
         if (!hold || rel >= done_rel) start = 1'b0;
         if (toggle) begin
            cfg_k = CW'($urandom_range(7, 0));
            cfg_c = CW'($urandom_range(7, 0));
            cfg_oc_tiles = CW'($urandom_range(7, 0));
            cfg_px_tiles = CW'($urandom_range(7, 0));
         end
      end
      check("busy_cycles", busy_cnt, done_rel - 1);
`ifdef CONV_SCHED_PERF_EN
      check("perf_cycles", perf_cycles, done_rel - 1);
`endif
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0;
      cfg_k = '0; cfg_c = '0; cfg_oc_tiles = '0; cfg_px_tiles = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      run_job(1, 1, 1, 1, 0, 0, 0);        // single read, single write
      run_job(3, 2, 2, 3, 0, 0, 0);        // L=18, 6 tiles
      run_job(3, 0, 2, 2, 0, 0, 0);        // C=0: straight to DONE
      run_job(2, 1, 0, 3, 0, 0, 0);        // no oc tiles
      run_job(1, 1, 3, 0, 0, 0, 0);        // no px tiles
      run_job(3, 5, 3, 1, 0, 0, 0);        // kernel addresses wrap
      run_job(1, 3, 1, 2, 0, 0, 2 + (3 + D + 2) + 1);  // reset in FEED of tile 2
      run_job(1, 3, 1, 2, 0, 0, 0);        // clean job after abort
      run_job(2, 2, 2, 2, 1, 1, 0);        // start held, cfg scrambled mid-job
      run_job(4, 8, 1, 1, 0, 0, 0);        // L=128 wraps to 0

      for (int n = 0; n < 10; n++)
         run_job($urandom_range(3, 1), $urandom_range(5, 0),
                 $urandom_range(3, 0), $urandom_range(3, 0),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
